dp_ram_arbiter: RTL and testbench

Round-robin arbiter that shares one port of the pipelined dual-port RAM (two-cycle registered read path) between `NUM_REQ` requesters. Each requester issues single-word read or write commands over a valid/ready handshake. The arbiter registers the winning command onto the RAM port and tracks reads through a tag pipeline matched to the RAM read latency, so every read datum returns tagged with its requester id. It sits between client engines and one RAM port; the other RAM port stays free for an independent agent.

---
 rtl/dp_ram_arbiter.sv | 123 ++++++++++++
 tb/tb_dp_ram_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dp_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dp_ram_arbiter
// Brief    : Round-robin arbiter sharing one pipelined RAM port between
//            NUM_REQ requesters; reads return tagged with the requester id.
// Revision : 1.0 - initial release
// ============================================================================
module dp_ram_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    localparam int ID_WIDTH  = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_wr,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic                          rsp_valid,
    output logic [ID_WIDTH-1:0]           rsp_id,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          ram_wr_en,
    output logic [ADDR_WIDTH-1:0]         ram_addr,
    output logic [DATA_WIDTH-1:0]         ram_din,
    input  logic [DATA_WIDTH-1:0]         ram_dout
);

    localparam logic [ID_WIDTH:0]   C_NUM_REQ = (ID_WIDTH+1)'(NUM_REQ);
    localparam logic [ID_WIDTH-1:0] C_LAST_ID = ID_WIDTH'(NUM_REQ - 1);

    logic [ID_WIDTH-1:0]   r_rr_ptr;
    logic                  r_cmd_valid;
    logic                  r_cmd_wr;
    logic [ID_WIDTH-1:0]   r_cmd_id;
    logic [ADDR_WIDTH-1:0] r_ram_addr;
    logic [DATA_WIDTH-1:0] r_ram_din;
    logic                  r_tag1_valid;
    logic [ID_WIDTH-1:0]   r_tag1_id;
    logic                  r_tag2_valid;
    logic [ID_WIDTH-1:0]   r_tag2_id;

    logic [ADDR_WIDTH-1:0] w_addr  [NUM_REQ];
    logic [DATA_WIDTH-1:0] w_wdata [NUM_REQ];
    logic [NUM_REQ-1:0]    w_grant;
    logic [ID_WIDTH-1:0]   w_gnt_id;
    logic                  w_found;
    logic [ID_WIDTH:0]     w_idx;
    logic                  w_hs;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign w_addr[gi]  = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign w_wdata[gi] = req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // Search upward from the pointer, wrapping modulo NUM_REQ (which need
    // not be a power of two).
    always_comb begin
        w_grant  = '0;
        w_gnt_id = '0;
        w_found  = 1'b0;
        w_idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = {1'b0, r_rr_ptr} + (ID_WIDTH+1)'(k);
            if (w_idx >= C_NUM_REQ) begin
                w_idx = w_idx - C_NUM_REQ;
            end
            if (!w_found && req_valid[w_idx[ID_WIDTH-1:0]]) begin
                w_found  = 1'b1;
                w_gnt_id = w_idx[ID_WIDTH-1:0];
            end
        end
        if (w_found && !reset) begin
            w_grant[w_gnt_id] = 1'b1;
        end
    end

    assign req_ready = w_grant;
    assign w_hs      = |w_grant;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr     <= '0;
            r_cmd_valid  <= 1'b0;
            r_cmd_wr     <= 1'b0;
            r_cmd_id     <= '0;
            r_ram_addr   <= '0;
            r_ram_din    <= '0;
            r_tag1_valid <= 1'b0;
            r_tag1_id    <= '0;
            r_tag2_valid <= 1'b0;
            r_tag2_id    <= '0;
        end else begin
            if (w_hs) begin
                r_cmd_valid <= 1'b1;
                r_cmd_wr    <= req_wr[w_gnt_id];
                r_cmd_id    <= w_gnt_id;
                r_ram_addr  <= w_addr[w_gnt_id];
                r_ram_din   <= w_wdata[w_gnt_id];
                r_rr_ptr    <= (w_gnt_id == C_LAST_ID) ? '0 : w_gnt_id + 1'b1;
            end else begin
                r_cmd_valid <= 1'b0;
            end
            // Tags track the RAM's two-stage read pipeline one-for-one.
            r_tag1_valid <= r_cmd_valid & ~r_cmd_wr;
            r_tag1_id    <= r_cmd_id;
            r_tag2_valid <= r_tag1_valid;
            r_tag2_id    <= r_tag1_id;
        end
    end

    assign ram_wr_en = r_cmd_valid & r_cmd_wr;
    assign ram_addr  = r_ram_addr;
    assign ram_din   = r_ram_din;
    assign rsp_valid = r_tag2_valid;
    assign rsp_id    = r_tag2_id;
    assign rsp_data  = ram_dout;

endmodule
`default_nettype wire

// File: tb/tb_dp_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dp_ram_arbiter
// Brief    : Randomized self-checking bench with a transaction-level model of
//            the arbiter and an attached two-cycle read-latency RAM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dp_ram_arbiter;

    localparam int N  = 4;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_ready;
    logic [N-1:0]      req_wr = '0;
    logic [N*AW-1:0]   req_addr = '0;
    logic [N*DW-1:0]   req_wdata = '0;
    logic              rsp_valid;
    logic [IW-1:0]     rsp_id;
    logic [DW-1:0]     rsp_data;
    logic              ram_wr_en;
    logic [AW-1:0]     ram_addr;
    logic [DW-1:0]     ram_din;
    logic [DW-1:0]     ram_dout;

    dp_ram_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .ram_wr_en(ram_wr_en), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_val(input int a);
        if (a == 5) return 32'hDEADBEEF;
        return DW'(32'hA5A50000 ^ (a * 32'h00010003));
    endfunction

    // Attached RAM port: read-before-write, two registered read stages.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] rd1, rd2;
    always @(posedge clk) begin
        rd1 <= mem[ram_addr];
        if (ram_wr_en) mem[ram_addr] <= ram_din;
        rd2 <= rd1;
    end
    assign ram_dout = rd2;

    // Reference model state
    typedef struct { int due; int id; logic [DW-1:0] data; } rsp_t;
    rsp_t          exp_q[$];
    logic [DW-1:0] shadow [0:(1<<AW)-1];
    int            m_ptr = 0;
    logic          exp_wr_en = 1'b0;
    logic [AW-1:0] exp_addr = '0;
    logic [DW-1:0] exp_din = '0;
    int            cyc = 0;

    int vectors = 0;
    int miscompares = 0;

    logic [N-1:0]  d_valid;
    logic [N-1:0]  d_wr;
    logic [AW-1:0] d_addr  [N];
    logic [DW-1:0] d_wdata [N];

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic clear_drive();
        d_valid = '0;
        d_wr    = '0;
        for (int i = 0; i < N; i++) begin
            d_addr[i]  = '0;
            d_wdata[i] = '0;
        end
    endtask

    task automatic randomize_drive(input int valid_pct);
        for (int i = 0; i < N; i++) begin
            d_valid[i] = ($urandom_range(0, 99) < valid_pct);
            d_wr[i]    = $urandom_range(0, 2) == 0;
            d_addr[i]  = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
            d_wdata[i] = DW'($urandom);
        end
    endtask

    // One clock cycle: drive after the rising edge, check and advance the
    // model at the falling edge.
    task automatic cycle(input logic rst_i);
        int            g;
        logic [N-1:0]  exp_ready;
        logic          exp_v;
        rsp_t          r;
        @(posedge clk);
        #1;
        cyc++;
        reset     = rst_i;
        req_valid = d_valid;
        req_wr    = d_wr;
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW]  = d_addr[i];
            req_wdata[i*DW +: DW] = d_wdata[i];
        end
        @(negedge clk);
        g = rst_i ? -1 : pick(d_valid, m_ptr);
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        check_val("req_ready", 64'(req_ready), 64'(exp_ready));
        check_val("ram_wr_en", 64'(ram_wr_en), 64'(exp_wr_en));
        check_val("ram_addr", 64'(ram_addr), 64'(exp_addr));
        check_val("ram_din", 64'(ram_din), 64'(exp_din));
        exp_v = (exp_q.size() > 0) && (exp_q[0].due == cyc);
        check_val("rsp_valid", 64'(rsp_valid), 64'(exp_v));
        if (exp_v) begin
            r = exp_q.pop_front();
            check_val("rsp_id", 64'(rsp_id), 64'(r.id));
            check_val("rsp_data", 64'(rsp_data), 64'(r.data));
        end
        if (rst_i) begin
            exp_q.delete();
            m_ptr     = 0;
            exp_wr_en = 1'b0;
            exp_addr  = '0;
            exp_din   = '0;
        end else if (g >= 0) begin
            if (!d_wr[g]) begin
                r.due  = cyc + 3;
                r.id   = g;
                r.data = shadow[d_addr[g]];
                exp_q.push_back(r);
            end else begin
                shadow[d_addr[g]] = d_wdata[g];
            end
            exp_wr_en = d_wr[g];
            exp_addr  = d_addr[g];
            exp_din   = d_wdata[g];
            m_ptr     = (g + 1) % N;
        end else begin
            exp_wr_en = 1'b0;
        end
    endtask

    task automatic one_cmd(input int id, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        clear_drive();
        d_valid[id] = 1'b1;
        d_wr[id]    = wr;
        d_addr[id]  = a;
        d_wdata[id] = d;
        cycle(1'b0);
    endtask

    task automatic idle(input int n);
        clear_drive();
        for (int i = 0; i < n; i++) cycle(1'b0);
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i]    = init_val(i);
            shadow[i] = init_val(i);
        end
        rd1 = '0;
        rd2 = '0;

        // Reset with requests present: no grants may appear.
        for (int i = 0; i < 3; i++) begin
            randomize_drive(80);
            cycle(1'b1);
        end
        idle(2);

        // Single read of preloaded word by requester 2.
        one_cmd(2, 1'b0, AW'(10'h005), '0);
        idle(4);

        // Fairness: all requesters valid, then requester 1 alone.
        for (int i = 0; i < 8; i++) begin
            randomize_drive(100);
            cycle(1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            randomize_drive(0);
            d_valid[1] = 1'b1;
            cycle(1'b0);
        end
        idle(4);

        // Write then read of the same address by different requesters.
        one_cmd(0, 1'b1, AW'(10'h3FF), 32'h12345678);
        one_cmd(3, 1'b0, AW'(10'h3FF), '0);
        idle(4);

        // Pointer wrap: grant 3, idle, then 1 and 3 contend.
        one_cmd(3, 1'b0, AW'(10'h001), '0);
        idle(5);
        randomize_drive(0);
        d_valid[1] = 1'b1;
        d_valid[3] = 1'b1;
        cycle(1'b0);
        idle(4);

        // Reset with reads in flight.
        one_cmd(0, 1'b0, AW'(10'h002), '0);
        one_cmd(1, 1'b0, AW'(10'h003), '0);
        randomize_drive(100);
        cycle(1'b1);
        idle(1);
        one_cmd(2, 1'b0, AW'(10'h005), '0);
        idle(4);

        // Back-to-back R/W/R.
        one_cmd(0, 1'b0, AW'(10'h006), '0);
        one_cmd(1, 1'b1, AW'(10'h006), 32'hCAFEF00D);
        one_cmd(2, 1'b0, AW'(10'h006), '0);
        idle(4);

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            randomize_drive($urandom_range(10, 90));
            cycle($urandom_range(0, 149) == 0);
        end
        idle(5);
        check_val("drain", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
